// File: rtl/arm_isa_pkg.sv
// Purpose: ARM ISA constants and types shared by the instruction encoder and decoder.
// Latency: none (types, constants and one combinational helper).
// Backpressure: none.
package arm_isa_pkg;

  localparam int WORD_W = 32;

  // Instruction class codes carried on the 3-bit instr_class bus.
  typedef enum logic [2:0] {
    CLS_DP_REG = 3'b000,
    CLS_DP_IMM = 3'b001,
    CLS_LS_IMM = 3'b010,
    CLS_LS_REG = 3'b011,
    CLS_BRANCH = 3'b101
  } instr_class_e;

  // Condition codes, bits [31:28].
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_AL = 4'hE;

  // Data-processing opcodes, bits [24:21].
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_MVN = 4'hF;

  // Shift types, bits [6:5].
  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  // Field bundle captured at accept (imm32 is held by the rotation search).
  typedef struct packed {
    logic [2:0]  instr_class;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        set_flags;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic [1:0]  shift;
    logic [4:0]  shift_amount;
    logic        use_rs;
    logic        p;
    logic        u;
    logic        b;
    logic        w;
    logic        l;
    logic [11:0] offset_12;
    logic        link;
    logic [23:0] signed_immed_24;
  } fields_t;

  // Rotate left; the doubled word makes a zero amount fall out naturally.
  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

endpackage

// File: rtl/arm_rot_imm_search.sv
// Purpose: serial search of the 16 even rotations for an ARM imm8/rotate_imm pair.
// Latency: done pulses rot+1 cycles after start (rot = winning rotation, 15 when none).
// Backpressure: none; a start restarts the search, results hold until the next done.
// Ports: start/imm32 in; done (1-cycle pulse), found, imm8, rotate_imm out.
module arm_rot_imm_search
  import arm_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] imm32,
  output logic        done,
  output logic        found,
  output logic [7:0]  imm8,
  output logic [3:0]  rotate_imm
);

  logic        busy;
  logic [3:0]  rot;
  logic [31:0] imm_q;
  logic [31:0] rotated;
  logic        match;

  // imm32 == ROR(imm8, 2*rot) exactly when ROL(imm32, 2*rot) fits in 8 bits.
  assign rotated = rol32(imm_q, {rot, 1'b0});
  assign match   = (rotated[31:8] == 24'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      rot        <= 4'd0;
      imm_q      <= 32'd0;
      done       <= 1'b0;
      found      <= 1'b0;
      imm8       <= 8'd0;
      rotate_imm <= 4'd0;
    end else begin
      done <= 1'b0;
      if (start) begin
        imm_q <= imm32;
        busy  <= 1'b1;
        rot   <= 4'd0;
      end else if (busy) begin
        // Ascending order, so the first hit is the lowest legal rotation.
        if (match || rot == 4'd15) begin
          done       <= 1'b1;
          found      <= match;
          imm8       <= rotated[7:0];
          rotate_imm <= rot;
          busy       <= 1'b0;
          rot        <= 4'd0;
        end else begin
          rot <= rot + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/arm_instr_encoder.sv
// Purpose: packs decoded ARM field bundles into 32-bit instruction words (decoder inverse).
// Latency: 1 cycle accept->out_valid; DP-imm rot+2 (17 when no legal rotation exists).
// Backpressure: one-entry output buffer; in_ready low from accept until the output handshake.
// Ports: in_valid/in_ready + field bundle in; out_valid/out_ready, instruction, out_error out.
module arm_instr_encoder
  import arm_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  instr_class,
  input  logic [3:0]  cond,
  input  logic [3:0]  opcode,
  input  logic        set_flags,
  input  logic [3:0]  rd,
  input  logic [3:0]  rn,
  input  logic [3:0]  rm,
  input  logic [3:0]  rs,
  input  logic [1:0]  shift,
  input  logic [4:0]  shift_amount,
  input  logic        use_rs,
  input  logic [31:0] imm32,
  input  logic        p,
  input  logic        u,
  input  logic        b,
  input  logic        w,
  input  logic        l,
  input  logic [11:0] offset_12,
  input  logic        link,
  input  logic [23:0] signed_immed_24,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction,
  output logic        out_error
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_OUTPUT} state_e;

  state_e      state;
  fields_t     fin, fq;
  logic        accept, start;
  logic        srch_done, srch_found;
  logic [7:0]  srch_imm8;
  logic [3:0]  srch_rot;
  logic [31:0] enc_word;
  logic        enc_err;

  assign accept = in_valid & in_ready;
  assign start  = accept & (instr_class == CLS_DP_IMM);

  assign fin = '{instr_class: instr_class, cond: cond, opcode: opcode, set_flags: set_flags,
                 rd: rd, rn: rn, rm: rm, rs: rs, shift: shift, shift_amount: shift_amount,
                 use_rs: use_rs, p: p, u: u, b: b, w: w, l: l, offset_12: offset_12,
                 link: link, signed_immed_24: signed_immed_24};

  arm_rot_imm_search u_search (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imm32      (imm32),
    .done       (srch_done),
    .found      (srch_found),
    .imm8       (srch_imm8),
    .rotate_imm (srch_rot)
  );

  // Format mux over the captured bundle; error cases leave the word at zero.
  always_comb begin
    enc_word = 32'd0;
    enc_err  = 1'b0;
    case (fq.instr_class)
      CLS_DP_REG:
        if (fq.use_rs)
          enc_word = {fq.cond, 3'b000, fq.opcode, fq.set_flags, fq.rn, fq.rd,
                      fq.rs, 1'b0, fq.shift, 1'b1, fq.rm};
        else
          enc_word = {fq.cond, 3'b000, fq.opcode, fq.set_flags, fq.rn, fq.rd,
                      fq.shift_amount, fq.shift, 1'b0, fq.rm};
      CLS_DP_IMM:
        if (srch_found)
          enc_word = {fq.cond, 3'b001, fq.opcode, fq.set_flags, fq.rn, fq.rd,
                      srch_rot, srch_imm8};
        else
          enc_err = 1'b1;
      CLS_LS_IMM:
        enc_word = {fq.cond, 3'b010, fq.p, fq.u, fq.b, fq.w, fq.l, fq.rn, fq.rd, fq.offset_12};
      CLS_LS_REG:
        enc_word = {fq.cond, 3'b011, fq.p, fq.u, fq.b, fq.w, fq.l, fq.rn, fq.rd,
                    fq.shift_amount, fq.shift, 1'b0, fq.rm};
      CLS_BRANCH:
        enc_word = {fq.cond, 3'b101, fq.link, fq.signed_immed_24};
      default:
        enc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fq          <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      instruction <= 32'd0;
      out_error   <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (accept) begin
            fq       <= fin;
            in_ready <= 1'b0;
            state    <= start ? S_SEARCH : S_OUTPUT;
          end
        S_SEARCH:
          // Search results are registered, so the word is formatted the cycle after done.
          if (srch_done) begin
            out_valid   <= 1'b1;
            instruction <= enc_word;
            out_error   <= enc_err;
            state       <= S_OUTPUT;
          end
        S_OUTPUT:
          if (!out_valid) begin
            out_valid   <= 1'b1;
            instruction <= enc_word;
            out_error   <= enc_err;
          end else if (out_ready) begin
            // in_ready returns only after this edge: no accept in the handshake cycle.
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        default:
          state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_instr_encoder.sv
module tb_arm_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  instr_class;
  logic [3:0]  cond, opcode;
  logic        set_flags;
  logic [3:0]  rd, rn, rm, rs;
  logic [1:0]  shift;
  logic [4:0]  shift_amount;
  logic        use_rs;
  logic [31:0] imm32;
  logic        p, u, b, w, l;
  logic [11:0] offset_12;
  logic        link;
  logic [23:0] signed_immed_24;
  logic        out_valid, out_ready;
  logic [31:0] instruction;
  logic        out_error;

  always #5 clk = ~clk;

  arm_instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr_class(instr_class), .cond(cond), .opcode(opcode), .set_flags(set_flags),
    .rd(rd), .rn(rn), .rm(rm), .rs(rs), .shift(shift), .shift_amount(shift_amount),
    .use_rs(use_rs), .imm32(imm32), .p(p), .u(u), .b(b), .w(w), .l(l),
    .offset_12(offset_12), .link(link), .signed_immed_24(signed_immed_24),
    .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction),
    .out_error(out_error)
  );

  typedef struct packed {
    logic [2:0]  cls;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s;
    logic [3:0]  rd, rn, rm, rs;
    logic [1:0]  shift;
    logic [4:0]  shamt;
    logic        use_rs;
    logic [31:0] imm32;
    logic [4:0]  pubwl;
    logic [11:0] off12;
    logic        link;
    logic [23:0] imm24;
    logic [31:0] exp_ins;
    logic        exp_err;
    logic [7:0]  exp_lat;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t dp_imm(input logic [3:0] op, input logic [3:0] rn_, input logic [3:0] rd_,
                                  input logic [31:0] imm, input logic [31:0] exp, input logic err,
                                  input logic [7:0] lat);
    vec_t v = '0;
    v.cls = 3'b001; v.cond = 4'hE; v.opcode = op; v.rn = rn_; v.rd = rd_; v.imm32 = imm;
    v.exp_ins = exp; v.exp_err = err; v.exp_lat = lat;
    return v;
  endfunction

  function automatic vec_t dp_reg(input logic [3:0] op, input logic s_, input logic [3:0] rn_,
                                  input logic [3:0] rd_, input logic [4:0] sa, input logic [1:0] sh,
                                  input logic urs, input logic [3:0] rs_, input logic [3:0] rm_,
                                  input logic [31:0] exp);
    vec_t v = '0;
    v.cls = 3'b000; v.cond = 4'hE; v.opcode = op; v.s = s_; v.rn = rn_; v.rd = rd_;
    v.shamt = sa; v.shift = sh; v.use_rs = urs; v.rs = rs_; v.rm = rm_;
    v.exp_ins = exp; v.exp_lat = 8'd1;
    return v;
  endfunction

  function automatic vec_t ls(input logic [2:0] cls, input logic [4:0] pubwl, input logic [3:0] rn_,
                              input logic [3:0] rd_, input logic [11:0] off, input logic [4:0] sa,
                              input logic [1:0] sh, input logic [3:0] rm_, input logic [31:0] exp);
    vec_t v = '0;
    v.cls = cls; v.cond = 4'hE; v.pubwl = pubwl; v.rn = rn_; v.rd = rd_; v.off12 = off;
    v.shamt = sa; v.shift = sh; v.rm = rm_; v.exp_ins = exp; v.exp_lat = 8'd1;
    return v;
  endfunction

  function automatic vec_t br(input logic [3:0] c, input logic lk, input logic [23:0] off,
                              input logic [31:0] exp);
    vec_t v = '0;
    v.cls = 3'b101; v.cond = c; v.link = lk; v.imm24 = off; v.exp_ins = exp; v.exp_lat = 8'd1;
    return v;
  endfunction

  function automatic vec_t bad(input logic [2:0] cls);
    vec_t v = '0;
    v.cls = cls; v.cond = 4'hE; v.rd = 4'h3; v.imm24 = 24'h123456;
    v.exp_ins = 32'd0; v.exp_err = 1'b1; v.exp_lat = 8'd1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    instr_class = v.cls; cond = v.cond; opcode = v.opcode; set_flags = v.s;
    rd = v.rd; rn = v.rn; rm = v.rm; rs = v.rs; shift = v.shift; shift_amount = v.shamt;
    use_rs = v.use_rs; imm32 = v.imm32; {p, u, b, w, l} = v.pubwl; offset_12 = v.off12;
    link = v.link; signed_immed_24 = v.imm24;
  endtask

  // Present a bundle once in_ready is seen, then count edges from accept to out_valid.
  task automatic send(input vec_t v, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drive('0);  // later input changes must not matter
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  // Check one vector with out_ready high; the handshake completes on the next edge.
  task automatic run_vec(input string name, input vec_t v);
    int lat;
    send(v, lat);
    chk({name, " instr"}, instruction, v.exp_ins);
    chk({name, " err"}, {31'd0, out_error}, {31'd0, v.exp_err});
    chk({name, " lat"}, lat, {24'd0, v.exp_lat});
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[13];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hits;
    vecs[0]  = dp_imm(4'h4, 4'd1, 4'd2, 32'h0000_00FF, 32'hE281_20FF, 1'b0, 8'd2);
    vecs[1]  = dp_imm(4'hD, 4'd0, 4'd0, 32'hFF00_0000, 32'hE3A0_04FF, 1'b0, 8'd6);
    vecs[2]  = dp_imm(4'h4, 4'd1, 4'd2, 32'h0000_0101, 32'h0000_0000, 1'b1, 8'd17);
    vecs[3]  = ls(3'b010, 5'b11001, 4'd1, 4'd0, 12'h004, 5'd0, 2'd0, 4'd0, 32'hE591_0004);
    vecs[4]  = dp_reg(4'h4, 1'b0, 4'd1, 4'd0, 5'd0, 2'b00, 1'b1, 4'd3, 4'd2, 32'hE081_0312);
    vecs[5]  = dp_reg(4'h2, 1'b1, 4'd4, 4'd3, 5'd7, 2'b10, 1'b0, 4'd0, 4'd5, 32'hE054_33C5);
    vecs[6]  = dp_imm(4'hD, 4'd0, 4'd5, 32'h0000_0000, 32'hE3A0_5000, 1'b0, 8'd2);
    vecs[7]  = dp_imm(4'h4, 4'd0, 4'd0, 32'hC000_003F, 32'hE280_01FF, 1'b0, 8'd3);
    vecs[8]  = ls(3'b011, 5'b10100, 4'd2, 4'd1, 12'h000, 5'd2, 2'b00, 4'd3, 32'hE742_1103);
    vecs[9]  = br(4'h0, 1'b0, 24'h000010, 32'h0A00_0010);
    vecs[10] = bad(3'b100);
    vecs[11] = bad(3'b111);
    vecs[12] = dp_imm(4'h4, 4'd1, 4'd2, 32'h0000_03FC, 32'hE281_2FFF, 1'b0, 8'd17);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive('0);
    #12;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset instr", instruction, 32'd0);
    chk("reset err", {31'd0, out_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // BL held in the output buffer while the consumer stalls.
    out_ready = 1'b0;
    send(br(4'hE, 1'b1, 24'hFFFFFE, 32'hEBFF_FFFE), lat);
    chk("bl lat", lat, 32'd1);
    drive(vecs[3]);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bl hold%0d instr", k), instruction, 32'hEBFF_FFFE);
      chk($sformatf("bl hold%0d valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bl hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bl hs valid", {31'd0, out_valid}, 32'd0);
    chk("bl hs in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post-hs accept", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("post-hs valid", {31'd0, out_valid}, 32'd1);
    chk("post-hs instr", instruction, 32'hE591_0004);
    @(posedge clk);
    #1;

    // Reset during the search (rotation 7 under test).
    @(negedge clk);
    drive(vecs[2]);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst valid", {31'd0, out_valid}, 32'd0);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst instr", instruction, 32'd0);
    chk("midrst err", {31'd0, out_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) hits++;
    end
    chk("dropped bundle", hits, 32'd0);
    run_vec("after rst ldr", vecs[3]);
    run_vec("after rst cls110", bad(3'b110));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
